// File: rtl/mips_load_store_unit.sv
// Data-memory initiator for MIPS loads/stores: computes the effective address, runs one
// req/ack transaction and returns extended load data or a misalignment/bus error.
module mips_load_store_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       instruction,
  input  logic [31:0]       base,
  input  logic [31:0]       extend,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              addr_misaligned,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {StIdle, StReq, StDone, StMisal, StBusErr} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic [1:0]        off_q, off_d;
  size_e             size_q, size_d;
  logic              sign_q, sign_d;

  // Instruction decode
  logic        valid_op, is_store, is_signed, misaligned;
  size_e       size;
  logic [31:0] ea;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    valid_op  = 1'b1;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SzWord;
    case (instruction[31:26])
      6'b100000: begin size = SzByte; is_signed = 1'b1; end
      6'b100001: begin size = SzHalf; is_signed = 1'b1; end
      6'b100011: size = SzWord;
      6'b100100: size = SzByte;
      6'b100101: size = SzHalf;
      6'b101000: begin size = SzByte; is_store = 1'b1; end
      6'b101001: begin size = SzHalf; is_store = 1'b1; end
      6'b101011: begin size = SzWord; is_store = 1'b1; end
      default:   valid_op = 1'b0;
    endcase
  end

  assign ea = base + extend;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    case (size)
      SzByte:  be_calc = 4'b0001 << ea[1:0];
      SzHalf: begin
        be_calc    = ea[1] ? 4'b1100 : 4'b0011;
        misaligned = ea[0];
      end
      default: misaligned = (ea[1:0] != 2'b00);
    endcase
  end

  // Replicate the store datum across lanes, then keep only the enabled ones
  always_comb begin
    wdata_calc = store_data;
    case (size)
      SzByte:  wdata_calc = {4{store_data[7:0]}};
      SzHalf:  wdata_calc = {2{store_data[15:0]}};
      default: wdata_calc = store_data;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (!be_calc[i]) wdata_calc[8*i +: 8] = 8'h00;
    end
  end

  // Lane select and extension of the returned word
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ldata_ext;

  always_comb begin
    rbyte = mem_rdata[8*off_q +: 8];
    rhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SzByte:  ldata_ext = {{24{sign_q & rbyte[7]}}, rbyte};
      SzHalf:  ldata_ext = {{16{sign_q & rhalf[15]}}, rhalf};
      default: ldata_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    case (state_q)
      StIdle: begin
        if (start && valid_op) begin
          if (misaligned) begin
            state_d = StMisal;
          end else begin
            state_d = StReq;
            cnt_d   = 8'd0;
            we_d    = is_store;
            addr_d  = ea[ADDR_W+1:2];
            be_d    = be_calc;
            wdata_d = is_store ? wdata_calc : 32'h0;
            off_d   = ea[1:0];
            size_d  = size;
            sign_d  = is_signed;
          end
        end
      end
      StReq: begin
        // An ack on the final allowed cycle still completes the transaction
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) ldata_d = ldata_ext;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = StBusErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
      off_q   <= 2'b00;
      size_q  <= SzWord;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    mem_req         = (state_q == StReq);
    busy            = (state_q == StReq);
    done            = (state_q == StDone) || (state_q == StMisal) || (state_q == StBusErr);
    addr_misaligned = (state_q == StMisal);
    bus_error       = (state_q == StBusErr);
    mem_we          = we_q;
    mem_addr        = addr_q;
    mem_be          = be_q;
    mem_wdata       = wdata_q;
    load_data       = ldata_q;
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit: expected transactions are queued at issue time
// and compared when the unit presents its memory request and completion.
module tb_mips_load_store_unit;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 15;

  localparam logic [5:0] OpLb = 6'b100000, OpLh = 6'b100001, OpLw = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100, OpLhu = 6'b100101;
  localparam logic [5:0] OpSb = 6'b101000, OpSh = 6'b101001, OpSw = 6'b101011;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       instruction = '0, base = '0, extend = '0, store_data = '0;
  logic              busy, done, addr_misaligned, bus_error;
  logic [31:0]       load_data;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;

  mips_load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction), .base(base),
    .extend(extend), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .addr_misaligned(addr_misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic        berr;
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive start for one cycle; returns at the negedge of cycle k+1
  task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [31:0] e,
                       input logic [31:0] sd, input exp_t x);
    @(negedge clk);
    instruction = {op, 26'h0};
    base = b;
    extend = e;
    store_data = sd;
    start = 1'b1;
    sb_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  // ack_at: REQ cycle index carrying mem_ack, or -1 for never
  task automatic complete(input string tag, input int ack_at, input logic [31:0] rd);
    exp_t x;
    logic [31:0] mask;
    int n;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: got empty queue expected entry", tag);
      return;
    end
    x = sb_q.pop_front();
    if (x.mis) begin
      check({tag, "_mis_done"}, 32'(done), 32'd1);
      check({tag, "_mis_flag"}, 32'(addr_misaligned), 32'd1);
      check({tag, "_mis_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mis_busy"}, 32'(busy), 32'd0);
    end else begin
      check({tag, "_req"}, 32'(mem_req), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_we"}, 32'(mem_we), 32'(x.we));
      check({tag, "_addr"}, 32'(mem_addr), 32'(x.addr));
      check({tag, "_be"}, 32'(mem_be), 32'(x.be));
      if (x.we) begin
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{x.be[i]}};
        check({tag, "_wdata"}, mem_wdata & mask, x.wdata & mask);
      end
      n = 0;
      while (1) begin
        if (n == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        n++;
        if (done || !mem_req || n > 40) break;
      end
      check({tag, "_cycles"}, 32'(n), 32'(x.cycles));
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_berr"}, 32'(bus_error), 32'(x.berr));
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
    end
    check({tag, "_ldata"}, load_data, x.ldata);
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  function automatic exp_t mk(logic mis, logic berr, logic we, logic [7:0] addr,
                              logic [3:0] be, logic [31:0] wd, logic [31:0] ld, int cyc);
    exp_t x;
    x.mis = mis; x.berr = berr; x.we = we; x.addr = addr; x.be = be;
    x.wdata = wd; x.ldata = ld; x.cycles = cyc;
    return x;
  endfunction

  initial begin
    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ldata", load_data, 32'h0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;

    // LW ea=0x14, ack in first REQ cycle
    issue(OpLw, 32'h10, 32'h4, 32'h0, mk(0, 0, 0, 8'd5, 4'hf, 0, 32'hDEADBEEF, 1));
    complete("lw", 0, 32'hDEADBEEF);
    // LB / LBU ea=0x13
    issue(OpLb, 32'h10, 32'h3, 32'h0, mk(0, 0, 0, 8'd4, 4'b1000, 0, 32'hFFFFFF80, 1));
    complete("lb", 0, 32'h80000000);
    issue(OpLbu, 32'h10, 32'h3, 32'h0, mk(0, 0, 0, 8'd4, 4'b1000, 0, 32'h00000080, 1));
    complete("lbu", 0, 32'h80000000);
    // SH ea=0x22 via negative offset; load_data unchanged
    issue(OpSh, 32'h30, 32'hFFFFFFF2, 32'h0000ABCD,
          mk(0, 0, 1, 8'd8, 4'b1100, 32'hABCD0000, 32'h00000080, 1));
    complete("sh", 0, 32'h0);
    // Misaligned word and half
    issue(OpLw, 32'h6, 32'h0, 32'h0, mk(1, 0, 0, 0, 0, 0, 32'h00000080, 0));
    complete("lw_mis", -1, 32'h0);
    issue(OpLh, 32'h0, 32'h3, 32'h0, mk(1, 0, 0, 0, 0, 0, 32'h00000080, 0));
    complete("lh_mis", -1, 32'h0);
    // LH upper lane, ack in third cycle; LHU lower lane
    issue(OpLh, 32'h2, 32'h0, 32'h0, mk(0, 0, 0, 8'd0, 4'b1100, 0, 32'hFFFF8001, 3));
    complete("lh", 2, 32'h80017FFF);
    issue(OpLhu, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 8'd0, 4'b0011, 0, 32'h0000F00F, 1));
    complete("lhu", 0, 32'h0000F00F);
    // SW never acked -> bus error after TIMEOUT REQ cycles
    issue(OpSw, 32'h40, 32'h0, 32'h12345678,
          mk(0, 1, 1, 8'h10, 4'hf, 32'h12345678, 32'h0000F00F, TIMEOUT));
    complete("sw_to", -1, 32'h0);
    // SB ea=0x101 (upper bits dropped), ack on the last allowed cycle wins
    issue(OpSb, 32'h100, 32'h1, 32'h000000AB,
          mk(0, 0, 1, 8'h40, 4'b0010, 32'h0000AB00, 32'h0000F00F, TIMEOUT));
    complete("sb_late", TIMEOUT - 1, 32'h0);

    // Invalid opcode is ignored
    @(negedge clk);
    instruction = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("badop_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("badop_done", 32'(done), 32'd0);

    // Start during the DONE cycle is ignored
    issue(OpLw, 32'h0, 32'h0, 32'h0, mk(0, 0, 0, 8'd0, 4'hf, 0, 32'h11112222, 1));
    mem_ack = 1'b1;
    mem_rdata = 32'h11112222;
    @(negedge clk);
    mem_ack = 1'b0;
    check("dn_done", 32'(done), 32'd1);
    check("dn_ldata", load_data, 32'h11112222);
    void'(sb_q.pop_front());
    instruction = {OpLw, 26'h0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("dn_start_req", 32'(mem_req), 32'd0);
    check("dn_start_busy", 32'(busy), 32'd0);

    // Reset in the second REQ cycle abandons the transaction
    issue(OpLw, 32'h8, 32'h0, 32'h0, mk(0, 0, 0, 8'd2, 4'hf, 0, 32'h0, 1));
    @(negedge clk);
    check("rstreq_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstreq_req", 32'(mem_req), 32'd0);
    check("rstreq_busy", 32'(busy), 32'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    check("rstreq_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rstreq_done2", 32'(done), 32'd0);
    issue(OpLw, 32'h8, 32'h0, 32'h0, mk(0, 0, 0, 8'd2, 4'hf, 0, 32'hCAFEF00D, 1));
    complete("lw_after_rst", 0, 32'hCAFEF00D);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
